// File: rtl/shifter_operand_unit.sv
// Registered Val2 / shifter carry-out generator for the ARM execute stage.
// Optional macro SHIFTER_CARRY_EN enables the full shifter carry logic; otherwise carry_in passes through.
module shifter_operand_unit #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              select,
  input  logic              imm,
  input  logic [11:0]       shift_operand,
  input  logic [DATA_W-1:0] val_rm,
  input  logic [7:0]        val_rs,
  input  logic              carry_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] val2,
  output logic              carry_out
);

  localparam int SW = $clog2(DATA_W);
  localparam logic [8:0] W_AMT = 9'(DATA_W);

  function automatic logic [DATA_W-1:0] rotr(input logic [DATA_W-1:0] x, input logic [SW-1:0] r);
    logic [2*DATA_W-1:0] d;
    d = {x, x} >> r;
    return d[DATA_W-1:0];
  endfunction

  logic              accept;
  logic [8:0]        amt;
  logic [1:0]        sh_type;
  logic              rrx;
  logic              pass;
  logic [SW-1:0]     sh;
  logic              big;
  logic [8:0]        rot_amt;
  logic [DATA_W-1:0] imm_val;
  logic [DATA_W-1:0] lsl_val;
  logic [DATA_W-1:0] lsr_val;
  logic [DATA_W-1:0] asr_val;
  logic [DATA_W-1:0] ror_val;
  logic [DATA_W-1:0] shift_val;
  logic [DATA_W-1:0] next_val2;
  logic              next_carry;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Both shift forms reduce to (type, amount > 0) plus the pass-through and RRX special cases.
  always_comb begin
    amt     = '0;
    sh_type = shift_operand[6:5];
    rrx     = 1'b0;
    pass    = 1'b0;
    if (shift_operand[4]) begin
      amt  = {1'b0, val_rs};
      pass = (val_rs == 8'd0);
    end else begin
      amt = {4'b0, shift_operand[11:7]};
      if (shift_operand[11:7] == 5'd0) begin
        case (shift_operand[6:5])
          2'b00:   pass = 1'b1;
          2'b11:   rrx  = 1'b1;
          default: amt  = W_AMT;
        endcase
      end
    end
  end

  always_comb begin
    sh      = amt[SW-1:0];
    big     = (amt >= W_AMT);
    rot_amt = {3'b0, shift_operand[11:8], 1'b0};
    imm_val = rotr(DATA_W'(shift_operand[7:0]), rot_amt[SW-1:0]);
    lsl_val = val_rm << sh;
    lsr_val = val_rm >> sh;
    asr_val = $signed(val_rm) >>> sh;
    ror_val = rotr(val_rm, sh);
  end

  // Value path; amounts at or beyond the width saturate instead of wrapping.
  always_comb begin
    shift_val = val_rm;
    if (pass) begin
      shift_val = val_rm;
    end else if (rrx) begin
      shift_val = {carry_in, val_rm[DATA_W-1:1]};
    end else begin
      case (sh_type)
        2'b00:   shift_val = big ? '0 : lsl_val;
        2'b01:   shift_val = big ? '0 : lsr_val;
        2'b10:   shift_val = big ? {DATA_W{val_rm[DATA_W-1]}} : asr_val;
        default: shift_val = (sh == '0) ? val_rm : ror_val;
      endcase
    end

    if (select) begin
      next_val2 = {{(DATA_W-12){shift_operand[11]}}, shift_operand};
    end else if (imm) begin
      next_val2 = imm_val;
    end else begin
      next_val2 = shift_val;
    end
  end

`ifdef SHIFTER_CARRY_EN
  logic [DATA_W:0] lsl_ext;
  logic [DATA_W:0] lsr_ext;
  logic            eq;
  logic            shift_carry;

  // The extra bit of each widened shift lands on the last bit shifted out.
  always_comb begin
    lsl_ext     = {1'b0, val_rm} << sh;
    lsr_ext     = {val_rm, 1'b0} >> sh;
    eq          = (amt == W_AMT);
    shift_carry = carry_in;
    if (pass) begin
      shift_carry = carry_in;
    end else if (rrx) begin
      shift_carry = val_rm[0];
    end else begin
      case (sh_type)
        2'b00:   shift_carry = big ? (eq && val_rm[0]) : lsl_ext[DATA_W];
        2'b01:   shift_carry = big ? (eq && val_rm[DATA_W-1]) : lsr_ext[0];
        2'b10:   shift_carry = big ? val_rm[DATA_W-1] : lsr_ext[0];
        default: shift_carry = (sh == '0) ? val_rm[DATA_W-1] : ror_val[DATA_W-1];
      endcase
    end

    if (select) begin
      next_carry = carry_in;
    end else if (imm) begin
      next_carry = (shift_operand[11:8] == 4'd0) ? carry_in : imm_val[DATA_W-1];
    end else begin
      next_carry = shift_carry;
    end
  end
`else
  assign next_carry = carry_in;
`endif

  // Output register holds until drained; a simultaneous drain and accept simply overwrites it.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      val2      <= '0;
      carry_out <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      val2      <= next_val2;
      carry_out <= next_carry;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_shifter_operand_unit.sv
// Self-checking bench for shifter_operand_unit: directed cases, handshake/backpressure and random ops.
// Carry expectations follow SHIFTER_CARRY_EN the same way the design build does.
module tb_shifter_operand_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        select;
  logic        imm;
  logic [11:0] shift_operand;
  logic [31:0] val_rm;
  logic [7:0]  val_rs;
  logic        carry_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] val2;
  logic        carry_out;

  int checks = 0;
  int errors = 0;
  logic [31:0] last_val2;

  shifter_operand_unit #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .select(select), .imm(imm), .shift_operand(shift_operand),
    .val_rm(val_rm), .val_rs(val_rs), .carry_in(carry_in),
    .out_valid(out_valid), .out_ready(out_ready), .val2(val2), .carry_out(carry_out)
  );

  always #5 clk = ~clk;

  // ARM-style reference: shifts are performed one bit at a time, carry = last bit moved out.
  function automatic void ref_model(input logic s, input logic im, input logic [11:0] so,
                                    input logic [31:0] rm, input logic [7:0] rs, input logic cin,
                                    output logic [31:0] v, output logic c);
    int n;
    logic [1:0] kind;
    c = cin;
    v = rm;
    kind = so[6:5];
    n = 0;
    if (s) begin
      v = {{20{so[11]}}, so};
    end else if (im) begin
      v = {24'b0, so[7:0]};
      n = 2 * int'(so[11:8]);
      for (int i = 0; i < n; i++) begin
        c = v[0];
        v = {v[0], v[31:1]};
      end
    end else if (!so[4] && so[11:7] == 5'd0 && kind == 2'b11) begin
      v = {cin, rm[31:1]};
      c = rm[0];
    end else begin
      if (so[4]) n = int'(rs);
      else if (so[11:7] == 5'd0 && kind != 2'b00) n = 32;
      else n = int'(so[11:7]);
      for (int i = 0; i < n; i++) begin
        case (kind)
          2'b00: begin c = v[31]; v = v << 1; end
          2'b01: begin c = v[0];  v = v >> 1; end
          2'b10: begin c = v[0];  v = {v[31], v[31:1]}; end
          default: begin c = v[0]; v = {v[0], v[31:1]}; end
        endcase
      end
    end
`ifndef SHIFTER_CARRY_EN
    c = cin;
`endif
  endfunction

  task automatic apply_stimulus(input logic s, input logic im, input logic [11:0] so,
                                input logic [31:0] rm, input logic [7:0] rs, input logic cin);
    select = s;
    imm = im;
    shift_operand = so;
    val_rm = rm;
    val_rs = rs;
    carry_in = cin;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge with out_ready high; returns at the falling edge after the accept.
  task automatic run_op(input string tag, input logic s, input logic im, input logic [11:0] so,
                        input logic [31:0] rm, input logic [7:0] rs, input logic cin);
    logic [31:0] ev;
    logic ec;
    apply_stimulus(s, im, so, rm, rs, cin);
    in_valid = 1'b1;
    out_ready = 1'b1;
    ref_model(s, im, so, rm, rs, cin, ev, ec);
    #1;
    check_output({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check_output({tag, "_out_valid"}, 32'(out_valid), 32'd1);
    check_output({tag, "_val2"}, val2, ev);
    check_output({tag, "_carry"}, 32'(carry_out), 32'(ec));
    last_val2 = ev;
  endtask

  initial begin
    logic [31:0] av, bv, r;
    logic ac, bc;
    logic rs_small;

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    apply_stimulus(1'b0, 1'b0, 12'h000, 32'h0, 8'h0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_output("reset_out_valid", 32'(out_valid), 32'd0);
    check_output("reset_val2", val2, 32'd0);
    check_output("reset_carry", 32'(carry_out), 32'd0);
    rst = 1'b0;
    #1;
    check_output("reset_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);

    $display("[TB] directed cases");
    run_op("imm_4ff",    1'b0, 1'b1, 12'h4FF, 32'h12345678, 8'd0,  1'b0);
    run_op("rrx_c1",     1'b0, 1'b0, 12'h060, 32'h00000003, 8'd0,  1'b1);
    run_op("rrx_c0",     1'b0, 1'b0, 12'h060, 32'h00000003, 8'd0,  1'b0);
    run_op("lsr_rs32",   1'b0, 1'b0, 12'h030, 32'h80000000, 8'd32, 1'b0);
    run_op("lsr_rs33",   1'b0, 1'b0, 12'h030, 32'h80000000, 8'd33, 1'b1);
    run_op("lsr_rs0",    1'b0, 1'b0, 12'h030, 32'h80000000, 8'd0,  1'b1);
    run_op("lsl_rs32",   1'b0, 1'b0, 12'h010, 32'h00000001, 8'd32, 1'b0);
    run_op("asr_rs200",  1'b0, 1'b0, 12'h050, 32'h80000001, 8'd200, 1'b0);
    run_op("ror_rs64",   1'b0, 1'b0, 12'h070, 32'h80000001, 8'd64, 1'b0);
    run_op("asr_imm0",   1'b0, 1'b0, 12'h040, 32'h80000000, 8'd0,  1'b0);
    run_op("offset_ffc", 1'b1, 1'b1, 12'hFFC, 32'h0,        8'd0,  1'b1);

    $display("[TB] random cases");
    for (int i = 0; i < 300; i++) begin
      r = $urandom;
      rs_small = ($urandom_range(0, 1) == 0);
      run_op("rand", ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0), r[11:0],
             $urandom, rs_small ? 8'($urandom_range(0, 40)) : 8'($urandom), r[31]);
    end

    $display("[TB] drain and backpressure");
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_output("drain_out_valid", 32'(out_valid), 32'd0);
    check_output("drain_val2_kept", val2, last_val2);

    ref_model(1'b0, 1'b0, 12'h060, 32'h00000003, 8'd0, 1'b1, av, ac);
    ref_model(1'b0, 1'b0, 12'h030, 32'h80000000, 8'd32, 1'b0, bv, bc);
    apply_stimulus(1'b0, 1'b0, 12'h060, 32'h00000003, 8'd0, 1'b1);
    in_valid = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    apply_stimulus(1'b0, 1'b0, 12'h030, 32'h80000000, 8'd32, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check_output("stall_in_ready", 32'(in_ready), 32'd0);
      check_output("stall_out_valid", 32'(out_valid), 32'd1);
      check_output("stall_val2", val2, av);
      check_output("stall_carry", 32'(carry_out), 32'(ac));
      @(posedge clk);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    check_output("release_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b0;
    check_output("b_out_valid", 32'(out_valid), 32'd1);
    check_output("b_val2", val2, bv);
    check_output("b_carry", 32'(carry_out), 32'(bc));

    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_output("stall_rst_out_valid", 32'(out_valid), 32'd0);
    check_output("stall_rst_val2", val2, 32'd0);
    check_output("stall_rst_carry", 32'(carry_out), 32'd0);
    #1;
    check_output("stall_rst_in_ready", 32'(in_ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shifter_operand_unit.md
# shifter_operand_unit

Parametrised, registered second-operand (Val2) generator for the ARM execute stage. It produces the Val2 operand and the shifter carry-out for four input forms: 32-bit rotated immediate, immediate-amount shift, register-amount shift (Rs), and the 12-bit memory-offset path. Val2 and the carry-out are registered behind a valid/ready handshake, so the EXE stage can stall without losing an operand.

## Interface
- DATA_W, 32, datapath width; power of two, 16..64.
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept a request this cycle.
- select  in  1  memory-offset mode (LDR/STR).
- imm  in  1  I bit: rotated immediate.
- shift_operand  in  12  instruction bits [11:0].
- val_rm  in  DATA_W  Rm value.
- val_rs  in  8  Rs[7:0], the register shift amount.
- carry_in  in  1  current CPSR C.
- out_valid  out  1  val2/carry_out valid.
- out_ready  in  1  consumer accepts output.
- val2  out  DATA_W  registered operand.
- carry_out  out  1  registered shifter carry-out.

## Operation
- Decode priority: select > imm > shift_operand[4] (1 = register shift, 0 = immediate shift).
- Memory-offset mode: val2 = sign-extend(shift_operand[11:0]) to DATA_W; carry_out = carry_in.
- Immediate mode: val2 = ROR(zero-extend(shift_operand[7:0]), 2*shift_operand[11:8]).
  - Rotate field 0: carry_out = carry_in.
  - Otherwise: carry_out = val2[DATA_W-1].
- Immediate shift: amount n = shift_operand[11:7]; type = shift_operand[6:5] (00 LSL, 01 LSR, 10 ASR, 11 ROR).
  - LSL #0: val2 = rm, carry_out = carry_in.
  - LSR #0 is decoded as LSR #DATA_W; ASR #0 as ASR #DATA_W.
  - ROR #0 is RRX: val2 = {carry_in, rm[W-1:1]}, carry_out = rm[0].
- Register shift: amount n = val_rs[7:0], same type field.
  - n = 0 (all types): val2 = rm, carry_out = carry_in.
  - LSL/LSR, 1 ≤ n < W: normal shift; carry_out is the last bit shifted out.
  - LSL/LSR, n = W: val2 = 0; carry_out = rm[0] for LSL, rm[W-1] for LSR.
  - LSL/LSR, n > W: val2 = 0, carry_out = 0.
  - ASR, n ≥ W: val2 = all copies of rm[W-1]; carry_out = rm[W-1].
  - ROR, n ≠ 0 and n mod W = 0: val2 = rm, carry_out = rm[W-1].
  - ROR, otherwise: rotate by n mod W; carry_out = val2[W-1].
- ASR is arithmetic (sign-filling) in every path.
- Output register holds its contents until the value is accepted.
- val_rm, val_rs and carry_in are sampled only on the accept edge.

## Timing
- Accept condition: in_valid & in_ready.
- in_ready = !out_valid | out_ready. This is combinational, and the only combinational path through the unit.
- Latency: 1 cycle. Accept at edge k gives out_valid = 1 after edge k, with the result.
- Full throughput: 1 op/cycle while out_ready = 1.
- Stall: out_valid & !out_ready holds val2, carry_out and out_valid stable, and in_ready = 0.
- Simultaneous output drain and new accept: the register is overwritten with the new result; out_valid stays 1.
- Drain with no accept: out_valid goes to 0; val2 and carry_out keep their last values.
- Reset (any cycle, including mid-stall): out_valid = 0, val2 = 0, carry_out = 0. A pending output is discarded. in_ready = 1 in the cycle after reset.

## Configuration
- SHIFTER_CARRY_EN defined: carry_out is computed as in Operation.
- SHIFTER_CARRY_EN undefined:
  - carry_out = carry_in registered at accept (reset value 0).
  - The carry logic is removed; val2 is unchanged.

## Test plan
- Immediate: imm=1, shift_operand=12'h4FF, carry_in=0 -> val2=32'hFF000000, carry_out=1, out_valid one cycle after accept.
- RRX: imm=0, shift_operand=12'h060, val_rm=32'h00000003, carry_in=1 -> val2=32'h80000001, carry_out=1.
- Register LSR boundaries: shift_operand=12'h030, val_rm=32'h80000000.
  - val_rs=32 -> val2=0, carry_out=1.
  - val_rs=33 -> val2=0, carry_out=0.
  - val_rs=0 -> val2=32'h80000000, carry_out=carry_in.
- Offset mode: select=1, imm=1, shift_operand=12'hFFC, carry_in=1 -> val2=32'hFFFFFFFC, carry_out=1 (select overrides imm).
- Backpressure:
  - Two back-to-back requests A and B with out_ready=0 for 3 cycles -> A is held stable and in_ready=0.
  - Raise out_ready -> A is consumed and B is accepted the same cycle; B appears on the next cycle.
  - Assert rst during the stall -> out_valid=0, val2=0, carry_out=0 the following cycle.
- Macro off: rebuild without SHIFTER_CARRY_EN and rerun the RRX case -> val2=32'h80000001, carry_out=1 (carry_in pass-through). Rerun with carry_in=0 -> carry_out=0.
